// File: rtl/binary_mac_accum.sv
`default_nettype none
// ============================================================================
//  Module   : binary_mac_accum
//  Purpose  : Accumulates BEATS consecutive partial sums from the binary
//             dot-product unit into one full-length dot product. The result
//             is presented on a registered valid/ready output together with
//             a registered (result >= THRESH) flag.
//  Ports    : clock, reset      - clock / synchronous active-high reset
//             in_valid/in_ready - upstream handshake, in_data = partial sum
//             out_valid/out_ready - downstream handshake
//             out_data          - completed unsigned accumulation
//             out_fire          - registered threshold flag, valid with out_valid
//             beat_cnt          - beats accepted in the current group
//  Revision : 1.0  initial release
// ============================================================================
module binary_mac_accum #(
   parameter int          SIZE   = 4,
   parameter int          SETS   = 4,
   parameter int          BEATS  = 4,
   parameter int unsigned THRESH = 0,
   localparam int         IN_W   = (SIZE << 1) + SETS,
   localparam int         ACC_W  = IN_W + $clog2(BEATS),
   localparam int         CNT_W  = (BEATS > 1) ? $clog2(BEATS) : 1
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [IN_W-1:0]  in_data,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [ACC_W-1:0] out_data,
   output logic             out_fire,
   output logic [CNT_W-1:0] beat_cnt
);

   localparam logic [CNT_W-1:0] C_LAST_BEAT = CNT_W'(BEATS - 1);
   localparam logic [ACC_W-1:0] C_THRESH    = ACC_W'(THRESH);

   typedef enum logic [0:0] {
      ACC  = 1'b0,
      DONE = 1'b1
   } state_t;

   state_t           r_state, w_state_nxt;
   logic [ACC_W-1:0] r_acc, w_acc_nxt;
   logic [CNT_W-1:0] r_beat_cnt, w_beat_cnt_nxt;
   logic [ACC_W-1:0] r_out_data, w_out_data_nxt;
   logic             r_out_fire, w_out_fire_nxt;

   logic             w_accept;
   logic             w_last;
   logic             w_retire;
   logic [ACC_W-1:0] w_sum;
   logic             w_fire;

   // While a result is waiting, the input can only move when the result
   // retires in the same cycle; out_ready is passed straight through so
   // back-to-back groups see no bubble.
   assign in_ready  = (r_state == ACC) ? 1'b1 : out_ready;
   assign w_accept  = in_valid && in_ready;
   assign w_retire  = (r_state == DONE) && out_ready;
   assign w_sum     = r_acc + ACC_W'(in_data);
   // With BEATS=1 the counter never leaves 0, so every beat is the last one.
   assign w_last    = (r_beat_cnt == C_LAST_BEAT);

   // A zero threshold is always met; keep the compare out of the netlist.
   generate
      if (THRESH == 0) begin : g_thresh_zero
         assign w_fire = 1'b1;
      end else begin : g_thresh_cmp
         assign w_fire = (w_sum >= C_THRESH);
      end
   endgenerate

   always_ff @(posedge clock) begin
      if (reset) begin
         r_state    <= ACC;
         r_acc      <= '0;
         r_beat_cnt <= '0;
         r_out_data <= '0;
         r_out_fire <= 1'b0;
      end else begin
         r_state    <= w_state_nxt;
         r_acc      <= w_acc_nxt;
         r_beat_cnt <= w_beat_cnt_nxt;
         r_out_data <= w_out_data_nxt;
         r_out_fire <= w_out_fire_nxt;
      end
   end

   always_comb begin
      w_state_nxt    = r_state;
      w_acc_nxt      = r_acc;
      w_beat_cnt_nxt = r_beat_cnt;
      w_out_data_nxt = r_out_data;
      w_out_fire_nxt = r_out_fire;

      if (w_retire) begin
         w_state_nxt = ACC;
      end

      // An accept in DONE only happens together with a retire. The
      // accumulator and counter are already cleared in DONE, so the beat is
      // folded in exactly as it would be in ACC.
      if (w_accept) begin
         if (w_last) begin
            w_out_data_nxt = w_sum;
            w_out_fire_nxt = w_fire;
            w_acc_nxt      = '0;
            w_beat_cnt_nxt = '0;
            w_state_nxt    = DONE;
         end else begin
            w_acc_nxt      = w_sum;
            w_beat_cnt_nxt = r_beat_cnt + CNT_W'(1);
         end
      end
   end

   assign out_valid = (r_state == DONE);
   assign out_data  = r_out_data;
   assign out_fire  = r_out_fire;
   assign beat_cnt  = r_beat_cnt;

endmodule
`default_nettype wire

// File: tb/tb_binary_mac_accum.sv
`default_nettype none
// ============================================================================
//  Module   : tb_binary_mac_accum
//  Purpose  : Self-checking bench for binary_mac_accum. Instance A uses the
//             default parameters, instance T uses THRESH=128, instance B uses
//             BEATS=1. Instance A is driven from a vector table; the
//             remaining corner cases are hand-written sequences.
//  Revision : 1.0  initial release
// ============================================================================
module tb_binary_mac_accum;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   // ---------------- instance A : defaults ----------------
   logic        a_in_valid, a_in_ready, a_out_valid, a_out_ready, a_out_fire;
   logic [11:0] a_in_data;
   logic [13:0] a_out_data;
   logic [1:0]  a_beat_cnt;

   binary_mac_accum dut_a (
      .clock     (clk),
      .reset     (rst),
      .in_valid  (a_in_valid),
      .in_ready  (a_in_ready),
      .in_data   (a_in_data),
      .out_valid (a_out_valid),
      .out_ready (a_out_ready),
      .out_data  (a_out_data),
      .out_fire  (a_out_fire),
      .beat_cnt  (a_beat_cnt)
   );

   // ---------------- instance T : THRESH=128 ----------------
   logic        t_in_valid, t_in_ready, t_out_valid, t_out_ready, t_out_fire;
   logic [11:0] t_in_data;
   logic [13:0] t_out_data;
   logic [1:0]  t_beat_cnt;

   binary_mac_accum #(.THRESH(128)) dut_t (
      .clock     (clk),
      .reset     (rst),
      .in_valid  (t_in_valid),
      .in_ready  (t_in_ready),
      .in_data   (t_in_data),
      .out_valid (t_out_valid),
      .out_ready (t_out_ready),
      .out_data  (t_out_data),
      .out_fire  (t_out_fire),
      .beat_cnt  (t_beat_cnt)
   );

   // ---------------- instance B : BEATS=1 ----------------
   logic        b_in_valid, b_in_ready, b_out_valid, b_out_ready, b_out_fire;
   logic [11:0] b_in_data;
   logic [11:0] b_out_data;
   logic [0:0]  b_beat_cnt;

   binary_mac_accum #(.BEATS(1)) dut_b (
      .clock     (clk),
      .reset     (rst),
      .in_valid  (b_in_valid),
      .in_ready  (b_in_ready),
      .in_data   (b_in_data),
      .out_valid (b_out_valid),
      .out_ready (b_out_ready),
      .out_data  (b_out_data),
      .out_fire  (b_out_fire),
      .beat_cnt  (b_beat_cnt)
   );

   int errors = 0;
   int checks = 0;

   task automatic check(input string name, input int idx,
                        input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s[%0d]: got %0d expected %0d", name, idx, act, exp);
      end
   endtask

   // One vector: inputs for a cycle, expected in_ready before the edge,
   // expected registered outputs after it. Data/fire checked only when valid.
   typedef struct {
      logic        iv;
      logic [11:0] d;
      logic        ordy;
      logic        e_ir;
      logic        e_ov;
      logic [13:0] e_od;
      logic        e_of;
      logic [1:0]  e_bc;
   } vec_t;

   vec_t vecs[$];

   task automatic add(input logic iv, input logic [11:0] d, input logic ordy,
                      input logic e_ir, input logic e_ov, input logic [13:0] e_od,
                      input logic e_of, input logic [1:0] e_bc);
      vec_t v;
      v.iv = iv; v.d = d; v.ordy = ordy; v.e_ir = e_ir;
      v.e_ov = e_ov; v.e_od = e_od; v.e_of = e_of; v.e_bc = e_bc;
      vecs.push_back(v);
   endtask

   // Drive instance A for one cycle: inputs set 1 time unit after an edge,
   // in_ready sampled before the next edge, outputs sampled 1 unit after it.
   task automatic a_cycle(input logic iv, input logic [11:0] d, input logic ordy);
      a_in_valid = iv; a_in_data = d; a_out_ready = ordy;
      @(posedge clk); #1;
   endtask

   task automatic t_cycle(input logic iv, input logic [11:0] d);
      t_in_valid = iv; t_in_data = d; t_out_ready = 1'b1;
      @(posedge clk); #1;
   endtask

   initial begin
      rst = 1'b1;
      a_in_valid = 0; a_in_data = 0; a_out_ready = 0;
      t_in_valid = 0; t_in_data = 0; t_out_ready = 0;
      b_in_valid = 0; b_in_data = 0; b_out_ready = 0;

      // ---- vector table for instance A ----
      // 128,1,2,3 back-to-back, out_ready=1 -> 134 for one cycle
      add(1, 128, 1, 1, 0,   0, 0, 1);
      add(1,   1, 1, 1, 0,   0, 0, 2);
      add(1,   2, 1, 1, 0,   0, 0, 3);
      add(1,   3, 1, 1, 1, 134, 1, 0);
      add(0,   0, 1, 1, 0,   0, 0, 0);
      // group summing to 10 under out_ready=0, then backpressured beat of 5
      add(1,   1, 0, 1, 0,   0, 0, 1);
      add(1,   2, 0, 1, 0,   0, 0, 2);
      add(1,   3, 0, 1, 0,   0, 0, 3);
      add(1,   4, 0, 1, 1,  10, 1, 0);
      add(1,   5, 0, 0, 1,  10, 1, 0);
      add(1,   5, 0, 0, 1,  10, 1, 0);
      add(1,   5, 0, 0, 1,  10, 1, 0);
      add(1,   5, 1, 1, 0,   0, 0, 1);   // handshake cycle takes the 5
      add(1,   0, 1, 1, 0,   0, 0, 2);
      add(1,   0, 1, 1, 0,   0, 0, 3);
      add(1,   0, 0, 1, 1,   5, 1, 0);   // 5 was counted exactly once
      add(0,   0, 1, 1, 0,   0, 0, 0);
      // maximum partial sums with an idle cycle mid-group
      add(1, 4095, 1, 1, 0,     0, 0, 1);
      add(0,    0, 1, 1, 0,     0, 0, 1);
      add(1, 4095, 1, 1, 0,     0, 0, 2);
      add(1, 4095, 1, 1, 0,     0, 0, 3);
      add(1, 4095, 1, 1, 1, 16380, 1, 0);
      add(1,    7, 1, 1, 0,     0, 0, 1); // retire + accept, next group starts

      repeat (2) @(posedge clk);
      #1;
      // reset state, all instances
      check("rst_a_ov", 0, 32'(a_out_valid), 0);
      check("rst_a_od", 0, 32'(a_out_data),  0);
      check("rst_a_of", 0, 32'(a_out_fire),  0);
      check("rst_a_bc", 0, 32'(a_beat_cnt),  0);
      check("rst_a_ir", 0, 32'(a_in_ready),  1);
      check("rst_t_ov", 0, 32'(t_out_valid), 0);
      check("rst_b_ov", 0, 32'(b_out_valid), 0);
      check("rst_b_od", 0, 32'(b_out_data),  0);
      rst = 1'b0;

      // ---- table-driven run ----
      for (int i = 0; i < vecs.size(); i++) begin
         a_in_valid = vecs[i].iv; a_in_data = vecs[i].d; a_out_ready = vecs[i].ordy;
         #1;
         check("vec_ir", i, 32'(a_in_ready), 32'(vecs[i].e_ir));
         @(posedge clk); #1;
         check("vec_ov", i, 32'(a_out_valid), 32'(vecs[i].e_ov));
         check("vec_bc", i, 32'(a_beat_cnt),  32'(vecs[i].e_bc));
         if (vecs[i].e_ov) begin
            check("vec_od", i, 32'(a_out_data), 32'(vecs[i].e_od));
            check("vec_of", i, 32'(a_out_fire), 32'(vecs[i].e_of));
         end
      end

      // ---- reset mid-group (group currently holds 7, beat_cnt=1) ----
      a_cycle(1, 100, 1);
      a_cycle(1, 100, 1);
      check("mid_bc_before", 0, 32'(a_beat_cnt), 3);
      rst = 1'b1;
      a_cycle(1, 50, 1);                 // accept during reset is ignored
      rst = 1'b0;
      check("mid_bc_rst", 0, 32'(a_beat_cnt), 0);
      check("mid_ov_rst", 0, 32'(a_out_valid), 0);
      for (int k = 0; k < 3; k++) begin
         a_cycle(1, 1, 1);
         check("mid_ov_run", k, 32'(a_out_valid), 0);
      end
      a_cycle(1, 1, 1);
      check("mid_ov", 0, 32'(a_out_valid), 1);
      check("mid_od", 0, 32'(a_out_data), 4);
      a_cycle(0, 0, 1);
      check("mid_ov_end", 0, 32'(a_out_valid), 0);

      // ---- threshold 128 on instance T ----
      t_cycle(1, 0); t_cycle(1, 0); t_cycle(1, 0); t_cycle(1, 127);
      check("thr_ov_127", 0, 32'(t_out_valid), 1);
      check("thr_od_127", 0, 32'(t_out_data), 127);
      check("thr_of_127", 0, 32'(t_out_fire), 0);
      t_cycle(1, 0); t_cycle(1, 0); t_cycle(1, 0); t_cycle(1, 128);
      check("thr_ov_128", 0, 32'(t_out_valid), 1);
      check("thr_od_128", 0, 32'(t_out_data), 128);
      check("thr_of_128", 0, 32'(t_out_fire), 1);
      t_cycle(0, 0);
      check("thr_ov_end", 0, 32'(t_out_valid), 0);

      // ---- BEATS=1 streaming on instance B ----
      b_in_valid = 1; b_out_ready = 1;
      for (int k = 0; k < 3; k++) begin
         b_in_data = 12'(7 + k);
         #1;
         check("b1_ir", k, 32'(b_in_ready), 1);
         @(posedge clk); #1;
         check("b1_ov", k, 32'(b_out_valid), 1);
         check("b1_od", k, 32'(b_out_data), 32'(7 + k));
         check("b1_bc", k, 32'(b_beat_cnt), 0);
      end
      // stall: result held, input blocked
      b_out_ready = 0; b_in_data = 12'd20;
      #1;
      check("b1_stall_ir", 0, 32'(b_in_ready), 0);
      @(posedge clk); #1;
      check("b1_stall_ov", 0, 32'(b_out_valid), 1);
      check("b1_stall_od", 0, 32'(b_out_data), 9);
      b_in_valid = 0; b_out_ready = 1;
      @(posedge clk); #1;
      check("b1_end_ov", 0, 32'(b_out_valid), 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
`default_nettype wire
